// File: rtl/audio_multi_pcm_out.sv
// audio_multi_pcm_out: frame FIFO feeding one PWM or first-order delta-sigma modulator per channel.
// All channels share a single period counter and change samples together on the wrap edge.
module audio_multi_pcm_out #(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int MODE       = 0
) (
    input  logic                                 clk_audio,
    input  logic                                 aclr,
    input  logic                                 pcm_rdy,
    input  logic [CHANNELS*WIDTH-1:0]            pcm,
    input  logic                                 status_clr,
    output logic [CHANNELS-1:0]                  audio_out,
    output logic                                 fifo_full,
    output logic                                 fifo_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
    output logic                                 frame_strobe,
    output logic                                 overflow,
    output logic                                 underrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    // PWM period is 2^WIDTH-1 so a full-scale sample stays constantly high
    localparam logic [WIDTH-1:0] LAST = (MODE == 0) ? {{(WIDTH-1){1'b1}}, 1'b0} : {WIDTH{1'b1}};

    logic [CHANNELS*WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] lvl_q, lvl_d;
    logic [WIDTH-1:0] cnt_q;
    logic strobe_q, ovf_q, ovf_d, unr_q, unr_d;
    logic wrap, push, pop;

    assign fifo_full    = lvl_q == LW'(FIFO_DEPTH);
    assign fifo_empty   = lvl_q == '0;
    assign fifo_level   = lvl_q;
    assign frame_strobe = strobe_q;
    assign overflow     = ovf_q;
    assign underrun     = unr_q;

    always_comb begin
        wrap  = cnt_q == LAST;
        push  = pcm_rdy && !fifo_full;
        pop   = wrap && !fifo_empty;
        lvl_d = lvl_q + LW'(push) - LW'(pop);
        ovf_d = (pcm_rdy && fifo_full) || (ovf_q && !status_clr);
        unr_d = (wrap && fifo_empty) || (unr_q && !status_clr);
    end

    always_ff @(posedge clk_audio)
        if (push) mem_q[wr_q] <= pcm;

    always_ff @(posedge clk_audio) begin
        if (aclr) begin
            wr_q     <= '0;
            rd_q     <= '0;
            lvl_q    <= '0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            ovf_q    <= 1'b0;
            unr_q    <= 1'b0;
        end else begin
            wr_q     <= wr_q + AW'(push);
            rd_q     <= rd_q + AW'(pop);
            lvl_q    <= lvl_d;
            cnt_q    <= wrap ? '0 : cnt_q + 1'b1;
            strobe_q <= pop;
            ovf_q    <= ovf_d;
            unr_q    <= unr_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] smp_q;
        logic [WIDTH:0]   acc_q;
        logic             pwm_q;
        always_ff @(posedge clk_audio) begin
            if (aclr) begin
                smp_q <= '0;
                acc_q <= '0;
                pwm_q <= 1'b0;
            end else begin
                if (pop) smp_q <= mem_q[rd_q][(CHANNELS-1-c)*WIDTH +: WIDTH];
                acc_q <= {1'b0, acc_q[WIDTH-1:0]} + {1'b0, smp_q};
                pwm_q <= cnt_q < smp_q;
            end
        end
        assign audio_out[c] = (MODE == 0) ? pwm_q : acc_q[WIDTH];
    end
endmodule

// File: tb/tb_audio_multi_pcm_out.sv
// tb_audio_multi_pcm_out: PWM and delta-sigma instances driven in parallel against a queue-based model,
// plus literal duty-cycle and FIFO-limit expectations.
module tb_audio_multi_pcm_out;
    logic clk_audio, aclr, pcm_rdy, status_clr;
    logic [15:0] pcm;
    logic [1:0] ao [2];
    logic ff [2], fe [2], fs [2], ov [2], ur [2];
    logic [4:0] fl [2];
    int vectors, miscompares;
    bit started;

    audio_multi_pcm_out #(.CHANNELS(2), .WIDTH(8), .FIFO_DEPTH(16), .MODE(0)) d0 (
        .clk_audio(clk_audio), .aclr(aclr), .pcm_rdy(pcm_rdy), .pcm(pcm), .status_clr(status_clr),
        .audio_out(ao[0]), .fifo_full(ff[0]), .fifo_empty(fe[0]), .fifo_level(fl[0]),
        .frame_strobe(fs[0]), .overflow(ov[0]), .underrun(ur[0]));
    audio_multi_pcm_out #(.CHANNELS(2), .WIDTH(8), .FIFO_DEPTH(16), .MODE(1)) d1 (
        .clk_audio(clk_audio), .aclr(aclr), .pcm_rdy(pcm_rdy), .pcm(pcm), .status_clr(status_clr),
        .audio_out(ao[1]), .fifo_full(ff[1]), .fifo_empty(fe[1]), .fifo_level(fl[1]),
        .frame_strobe(fs[1]), .overflow(ov[1]), .underrun(ur[1]));

    initial begin
        clk_audio = 1'b0;
        forever #5 clk_audio = ~clk_audio;
    end

    function automatic void chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: one frame queue per instance, counter as plain modular arithmetic
    int mcnt [2];
    int msmp [2][2];
    int macc [2][2];
    bit mout [2][2];
    bit mfs [2], mov [2], mur [2];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    function automatic int qsize(int m);
        return m ? q1.size() : q0.size();
    endfunction

    always @(posedge clk_audio) begin : model
        int p, n;
        bit w;
        logic [15:0] f;
        for (int m = 0; m < 2; m++) begin
            if (aclr) begin
                mcnt[m] = 0;
                mfs[m] = 0; mov[m] = 0; mur[m] = 0;
                for (int c = 0; c < 2; c++) begin
                    msmp[m][c] = 0; macc[m][c] = 0; mout[m][c] = 0;
                end
                if (m == 1) q1.delete(); else q0.delete();
            end else begin
                p = (m == 1) ? 256 : 255;
                n = qsize(m);
                w = mcnt[m] == p - 1;
                for (int c = 0; c < 2; c++) begin
                    if (m == 0) mout[m][c] = mcnt[m] < msmp[m][c];
                    else begin
                        macc[m][c] = (macc[m][c] % 256) + msmp[m][c];
                        mout[m][c] = macc[m][c] >= 256;
                    end
                end
                mfs[m] = w && n > 0;
                mur[m] = (w && n == 0) || (mur[m] && !status_clr);
                mov[m] = (pcm_rdy && n == 16) || (mov[m] && !status_clr);
                if (mfs[m]) begin
                    f = (m == 1) ? q1.pop_front() : q0.pop_front();
                    msmp[m][0] = int'(f[15:8]);
                    msmp[m][1] = int'(f[7:0]);
                end
                if (pcm_rdy && n < 16) begin
                    if (m == 1) q1.push_back(pcm); else q0.push_back(pcm);
                end
                mcnt[m] = w ? 0 : mcnt[m] + 1;
            end
        end
    end

    always @(negedge clk_audio) begin
        if (started) begin
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < 2; c++)
                    chk($sformatf("d%0d.audio_out[%0d]", m, c), int'(ao[m][c]), int'(mout[m][c]));
                chk($sformatf("d%0d.frame_strobe", m), int'(fs[m]), int'(mfs[m]));
                chk($sformatf("d%0d.overflow", m), int'(ov[m]), int'(mov[m]));
                chk($sformatf("d%0d.underrun", m), int'(ur[m]), int'(mur[m]));
                chk($sformatf("d%0d.fifo_level", m), int'(fl[m]), qsize(m));
                chk($sformatf("d%0d.fifo_empty", m), int'(fe[m]), int'(qsize(m) == 0));
                chk($sformatf("d%0d.fifo_full", m), int'(ff[m]), int'(qsize(m) == 16));
            end
        end
    end

    task automatic wr(input logic [15:0] f);
        pcm = f;
        pcm_rdy = 1'b1;
        @(negedge clk_audio);
        pcm_rdy = 1'b0;
    endtask

    task automatic wait_fs(input int m);
        int t;
        t = 0;
        @(negedge clk_audio);
        while (!fs[m] && t < 700) begin
            @(negedge clk_audio);
            t++;
        end
        chk($sformatf("d%0d.strobe_wait", m), int'(fs[m]), 1);
    endtask

    task automatic wait_cnt(input int v);
        int t;
        t = 0;
        while (!(mcnt[0] == v && q0.size() == 0) && t < 5000) begin
            @(negedge clk_audio);
            t++;
        end
        chk("cnt_wait", int'(mcnt[0] == v && q0.size() == 0), 1);
    endtask

    task automatic count_win(input int m, input int c, input int n, output int k);
        k = 0;
        repeat (n) begin
            @(negedge clk_audio);
            k += int'(ao[m][c]);
        end
    endtask

    initial begin
        int k;
        logic [15:0] f;
        vectors = 0;
        miscompares = 0;
        started = 0;
        aclr = 1'b1; pcm_rdy = 1'b0; status_clr = 1'b0; pcm = '0;
        @(negedge clk_audio);
        started = 1;
        pcm_rdy = 1'b1;
        pcm = 16'hABCD;
        @(negedge clk_audio);
        pcm_rdy = 1'b0;
        aclr = 1'b0;
        chk("reset.fifo_empty", int'(fe[0]), 1);
        chk("reset.fifo_level", int'(fl[0]), 0);
        chk("reset.audio_out", int'(ao[0]), 0);
        repeat (260) @(negedge clk_audio);
        chk("idle.underrun", int'(ur[0]), 1);
        chk("idle.audio_out", int'(ao[1]), 0);
        status_clr = 1'b1;
        @(negedge clk_audio);
        status_clr = 1'b0;
        chk("quiet_clr.underrun", int'(ur[0]), 0);
        chk("quiet_clr.overflow", int'(ov[0]), 0);

        wr(16'h7F00);
        wait_fs(0);
        count_win(0, 0, 255, k);
        chk("pwm127.ch0_ones", k, 127);
        count_win(0, 1, 255, k);
        chk("pwm127.ch1_ones", k, 0);
        chk("pwm127.underrun_hold", int'(ur[0]), 1);

        wr(16'h00FF);
        wait_fs(0);
        count_win(0, 0, 255, k);
        chk("pwm0.ch0_ones", k, 0);
        count_win(0, 1, 255, k);
        chk("pwm255.ch1_ones", k, 255);

        wr({8'd64, 8'd200});
        wait_fs(1);
        repeat (256) @(negedge clk_audio);
        count_win(1, 0, 256, k);
        chk("ds64.ch0_ones", k, 64);
        count_win(1, 1, 256, k);
        chk("ds200.ch1_ones", k, 200);

        status_clr = 1'b1;
        @(negedge clk_audio);
        status_clr = 1'b0;
        wait_cnt(0);
        for (int i = 0; i < 17; i++) begin
            f = 16'($urandom);
            wr(f);
            if (i == 15) begin
                chk("burst.level16", int'(fl[0]), 16);
                chk("burst.full", int'(ff[0]), 1);
                chk("burst.no_overflow_yet", int'(ov[0]), 0);
            end
        end
        chk("burst.overflow", int'(ov[0]), 1);
        chk("burst.level_after_drop", int'(fl[0]), 16);
        repeat (17 * 256) @(negedge clk_audio);

        wait_cnt(254);
        status_clr = 1'b1;
        @(negedge clk_audio);
        status_clr = 1'b0;
        chk("wrap_clr.underrun", int'(ur[0]), 1);

        for (int i = 0; i < 6000; i++) begin
            pcm = 16'($urandom);
            pcm_rdy = $urandom_range(0, 99) < ((i < 3000) ? 1 : 12);
            status_clr = $urandom_range(0, 99) == 0;
            aclr = $urandom_range(0, 999) == 0;
            @(negedge clk_audio);
        end
        pcm_rdy = 1'b0; status_clr = 1'b0; aclr = 1'b0;
        repeat (3) @(negedge clk_audio);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
